// File: rtl/dac_pkg.sv
// dac_pkg: shared types and constants for the DAC SPI controller.
//   - FSM state enum (INIT only when DAC_SPI_CTRL_INIT_EN is defined)
//   - 4-bit DAC command codes, frame width, power-up argument
package dac_pkg;

  localparam int FRAME_W = 24;

  localparam logic [3:0]  CMD_WR_UPD    = 4'h3;     // write input reg and update DAC
  localparam logic [3:0]  CMD_SETUP_REF = 4'h8;     // reference setup
  localparam logic [19:0] REF_ON_ARG    = 20'h00001; // internal reference on

`ifdef DAC_SPI_CTRL_INIT_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, HOLD, INIT} dac_state_e;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} dac_state_e;
`endif

  // Write-and-update frame: {cmd, 1'b0, chan[2:0], data[15:0]}
  function automatic logic [FRAME_W-1:0] wr_frame(input logic [2:0] chan,
                                                  input logic [15:0] data);
    return {CMD_WR_UPD, 1'b0, chan, data};
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// dac_sclk_gen: SCLK divider for the DAC serial link.
//   clk  : system clock            rst  : sync active-high reset
//   en   : run divider (SHIFT only) sclk : SCLK level, idle high
//   rise : one-cycle strobe, SCLK goes high at the next edge
//   fall : one-cycle strobe, SCLK goes low at the next edge
// When disabled the divider is parked with SCLK high and count zero, so
// every frame starts with a full SCLK_DIV high phase.
module dac_sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(SCLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CNT_LAST);
  assign fall = en & last & sclk;
  assign rise = en & last & ~sclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (last) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_ctrl.sv
// dac_spi_ctrl: pops instructions from a FWFT queue and serialises each as a
// 24-bit write-and-update frame to an 8-channel SPI DAC.
//   clk_in, reset_in (sync, active-high)
//   data_in/chan_in/data_valid_in : queue head;  rd_ack_out : pop pulse
//   dac_sclk_out (idle high), dac_sync_n_out, dac_din_out (MSB first)
//   busy_out : state is not IDLE
// Build option: DAC_SPI_CTRL_INIT_EN -- after reset, send one reference-on
// frame (24'h800001) before serving the queue.
module dac_spi_ctrl
  import dac_pkg::*;
#(
  parameter int W_DATA   = 16,
  parameter int W_CHS    = 3,
  parameter int SCLK_DIV = 2,
  parameter int HOLD_CYC = 2
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [W_DATA-1:0] data_in,
  input  logic [W_CHS-1:0]  chan_in,
  input  logic              data_valid_in,
  output logic              rd_ack_out,
  output logic              dac_sclk_out,
  output logic              dac_sync_n_out,
  output logic              dac_din_out,
  output logic              busy_out
);

  localparam logic [4:0] BIT_LAST  = 5'(FRAME_W - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

  dac_state_e         state, state_nx;
  logic [FRAME_W-1:0] sreg;
  logic [4:0]         bit_cnt;
  logic [7:0]         hold_cnt;
  logic               sclk, sclk_rise, sclk_fall;
  logic               unused_fall;
`ifdef DAC_SPI_CTRL_INIT_EN
  logic               init_pend;
`endif

  // Data only moves on rising SCLK, so the falling strobe has no consumer.
  assign unused_fall = sclk_fall;

  dac_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .clk  (clk_in),
    .rst  (reset_in),
    .en   (state == SHIFT),
    .sclk (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  assign dac_sclk_out = sclk;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state    <= IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
`ifdef DAC_SPI_CTRL_INIT_EN
      init_pend <= 1'b1;
`endif
    end else begin
      state    <= state_nx;
      hold_cnt <= (state == HOLD) ? hold_cnt + 8'd1 : 8'd0;
      if (state != SHIFT) bit_cnt <= '0;
      case (state)
        LOAD: sreg <= wr_frame(3'(chan_in), 16'(data_in));
`ifdef DAC_SPI_CTRL_INIT_EN
        INIT: begin
          sreg      <= {CMD_SETUP_REF, REF_ON_ARG};
          init_pend <= 1'b0;
        end
`endif
        SHIFT: begin
          // Next bit is presented on the same edge SCLK returns high.
          if (sclk_rise) begin
            sreg    <= {sreg[FRAME_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx       = state;
    rd_ack_out     = 1'b0;
    busy_out       = 1'b1;
    dac_sync_n_out = 1'b1;
    dac_din_out    = 1'b0;
    case (state)
      IDLE: begin
        busy_out = 1'b0;
`ifdef DAC_SPI_CTRL_INIT_EN
        if (init_pend) state_nx = INIT;
        else
`endif
        if (data_valid_in) state_nx = LOAD;
      end
      LOAD: begin
        rd_ack_out = 1'b1;
        state_nx   = SHIFT;
      end
      SHIFT: begin
        dac_sync_n_out = 1'b0;
        dac_din_out    = sreg[FRAME_W-1];
        if (sclk_rise && bit_cnt == BIT_LAST) state_nx = HOLD;
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nx = IDLE;
      end
`ifdef DAC_SPI_CTRL_INIT_EN
      INIT: state_nx = SHIFT;
`endif
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// tb_dac_spi_ctrl: directed bench for dac_spi_ctrl. Instance a uses default
// parameters, instance b uses SCLK_DIV=1/HOLD_CYC=1; both share inputs and a
// frame monitor observes whichever instance is selected.
// With DAC_SPI_CTRL_INIT_EN defined only the reset and power-up frame
// scenarios run.
module tb_dac_spi_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [2:0]  chan;
  logic        valid;

  logic a_ack, a_sclk, a_sync, a_din, a_busy;
  logic b_ack, b_sclk, b_sync, b_din, b_busy;
  logic m_ack, m_sclk, m_sync, m_din, m_busy;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  dac_spi_ctrl u_a (
    .clk_in(clk), .reset_in(rst), .data_in(data), .chan_in(chan),
    .data_valid_in(valid), .rd_ack_out(a_ack), .dac_sclk_out(a_sclk),
    .dac_sync_n_out(a_sync), .dac_din_out(a_din), .busy_out(a_busy));

  dac_spi_ctrl #(.SCLK_DIV(1), .HOLD_CYC(1)) u_b (
    .clk_in(clk), .reset_in(rst), .data_in(data), .chan_in(chan),
    .data_valid_in(valid), .rd_ack_out(b_ack), .dac_sclk_out(b_sclk),
    .dac_sync_n_out(b_sync), .dac_din_out(b_din), .busy_out(b_busy));

  assign m_ack  = sel ? b_ack  : a_ack;
  assign m_sclk = sel ? b_sclk : a_sclk;
  assign m_sync = sel ? b_sync : a_sync;
  assign m_din  = sel ? b_din  : a_din;
  assign m_busy = sel ? b_busy : a_busy;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: samples on the falling clk edge, captures DIN on SCLK falls
  int          cyc = 0;
  int          ack_cnt = 0;
  int          ack_cyc[$];
  logic [23:0] frames[$];
  int          lows[$];
  int          nbits[$];
  logic [23:0] cap = '0;
  int          low_cnt = 0;
  int          bits = 0;
  int          sclk_bad = 0;
  logic        prev_sclk = 1'b1;
  logic        prev_sync = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (m_ack === 1'b1) begin
      ack_cnt++;
      ack_cyc.push_back(cyc);
    end
    if (m_sync === 1'b0) begin
      low_cnt++;
      if (prev_sclk === 1'b1 && m_sclk === 1'b0) begin
        cap = {cap[22:0], m_din};
        bits++;
      end
    end else if (m_sclk === 1'b0) begin
      sclk_bad++;
    end
    if (prev_sync === 1'b0 && m_sync === 1'b1) begin
      frames.push_back(cap);
      lows.push_back(low_cnt);
      nbits.push_back(bits);
      cap = '0; low_cnt = 0; bits = 0;
    end
    prev_sclk = m_sclk;
    prev_sync = m_sync;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    ack_cnt = 0;
    ack_cyc.delete();
    frames.delete();
    lows.delete();
    nbits.delete();
    sclk_bad = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Hold valid until the pop pulse, then drop it (data stays through LOAD)
  task automatic send_one(input logic [15:0] d, input logic [2:0] c);
    data = d; chan = c; valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (m_ack === 1'b1) break;
    end
    if (m_ack !== 1'b1) chk("ack_timeout", 32'd0, 32'd1);
    valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frames.size() < n; i++) tick();
    if (frames.size() < n) chk("frame_timeout", frames.size(), n);
  endtask

  initial begin
    rst = 1'b1; data = '0; chan = '0; valid = 1'b1;

    // Reset with valid asserted: nothing is popped, outputs at idle levels
    repeat (5) tick();
    chk("rst_ack",  m_ack,   1'b0);
    chk("rst_sclk", m_sclk,  1'b1);
    chk("rst_sync", m_sync,  1'b1);
    chk("rst_din",  m_din,   1'b0);
    chk("rst_busy", m_busy,  1'b0);
    chk("rst_pops", ack_cnt, 0);

`ifdef DAC_SPI_CTRL_INIT_EN
    // Valid high at release: reference-on frame first, then the queued word
    data = 16'hABCD; chan = 3'd5;
    rst = 1'b0;
    for (int i = 0; i < 300 && ack_cnt == 0; i++) tick();
    tick();
    valid = 1'b0;
    wait_frames(2, 400);
    chk("init_frame",  frames.size() > 0 ? frames[0] : 24'h0, 24'h800001);
    chk("init_low",    lows.size() > 0 ? lows[0] : 0, 96);
    chk("queued_frame", frames.size() > 1 ? frames[1] : 24'h0, 24'h35ABCD);
    chk("init_acks",   ack_cnt, 1);
    // The only pop happens after the init frame has fully left SYNC_N low
    chk("ack_after_init", ack_cyc.size() > 0 && ack_cyc[0] > 100, 1'b1);
`else
    valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    clr();

    // Single instruction: 16'hABCD on channel 5
    send_one(16'hABCD, 3'd5);
    wait_frames(1, 200);
    repeat (5) tick();
    chk("f1_frame", frames.size() > 0 ? frames[0] : 24'h0, 24'h35ABCD);
    chk("f1_low",   lows.size() > 0 ? lows[0] : 0, 96);
    chk("f1_bits",  nbits.size() > 0 ? nbits[0] : 0, 24);
    chk("f1_acks",  ack_cnt, 1);
    chk("f1_busy",  m_busy, 1'b0);
    chk("f1_sclk_idle_high", sclk_bad, 0);

    // Three queued instructions, valid held high, head advances after pop
    clr();
    begin
      logic [15:0] qd[3];
      logic [2:0]  qc[3];
      int          idx;
      qd[0] = 16'h1234; qc[0] = 3'd0;
      qd[1] = 16'hFFFF; qc[1] = 3'd7;
      qd[2] = 16'h8001; qc[2] = 3'd2;
      idx = 0;
      data = qd[0]; chan = qc[0]; valid = 1'b1;
      for (int i = 0; i < 500 && idx < 3; i++) begin
        tick();
        if (m_ack === 1'b1) begin
          idx++;
          tick();
          if (idx < 3) begin
            data = qd[idx]; chan = qc[idx];
          end else begin
            valid = 1'b0;
          end
        end
      end
    end
    wait_frames(3, 400);
    chk("q_acks",   ack_cnt, 3);
    chk("q_frame0", frames.size() > 0 ? frames[0] : 24'h0, 24'h301234);
    chk("q_frame1", frames.size() > 1 ? frames[1] : 24'h0, 24'h37FFFF);
    chk("q_frame2", frames.size() > 2 ? frames[2] : 24'h0, 24'h328001);
    chk("q_gap01",  ack_cyc.size() > 1 ? ack_cyc[1] - ack_cyc[0] : 0, 100);
    chk("q_gap12",  ack_cyc.size() > 2 ? ack_cyc[2] - ack_cyc[1] : 0, 100);

    // Valid and data toggled during SHIFT/HOLD: no extra pop, frame intact
    repeat (5) tick();
    clr();
    send_one(16'h0F0F, 3'd6);
    for (int i = 1; i <= 97; i++) begin
      tick();
      if (i == 1) begin
        data = 16'h5555; chan = 3'd3;
      end
      valid = i[0];
    end
    tick();
    valid = 1'b0;
    wait_frames(1, 100);
    repeat (150) tick();
    chk("tg_acks",   ack_cnt, 1);
    chk("tg_frames", frames.size(), 1);
    chk("tg_frame",  frames.size() > 0 ? frames[0] : 24'h0, 24'h360F0F);

    // Reset at the 10th SCLK: frame aborted immediately
    clr();
    send_one(16'hC3A5, 3'd1);
    for (int i = 0; i < 200 && bits < 10; i++) tick();
    chk("ab_reach10", bits, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_sync", m_sync, 1'b1);
    chk("ab_sclk", m_sclk, 1'b1);
    chk("ab_busy", m_busy, 1'b0);
    chk("ab_ack",  m_ack,  1'b0);
    repeat (20) tick();
    chk("ab_acks", ack_cnt, 1);
    chk("ab_partial_bits", nbits.size() > 0 ? nbits[0] : 0, 10);

    // SCLK_DIV=1, HOLD_CYC=1 instance: all-zero word on channel 0
    sel = 1'b1;
    do_reset();
    tick();
    clr();
    send_one(16'h0000, 3'd0);
    wait_frames(1, 100);
    repeat (5) tick();
    chk("b_frame", frames.size() > 0 ? frames[0] : 24'h0, 24'h300000);
    chk("b_low",   lows.size() > 0 ? lows[0] : 0, 48);
    chk("b_bits",  nbits.size() > 0 ? nbits[0] : 0, 24);
    chk("b_acks",  ack_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
